muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Multiply/divide controller for the EX stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers. Sequences multi-cycle mult/multu/div/divu and services mthi/mtlo/mfhi/mflo.
- Raises a pipeline stall when a HI/LO-touching instruction arrives while an operation is in flight.
- Decoded control bits come from the decoder via the ID/EX register.

Parameters:
- MUL_LAT, 4, cycles a multiply holds busy (legal range 1..15).
- W, 32, operand and HI/LO width (fixed at 32 for MIPS32).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mul_i  in  1  EX holds mult/multu.
- div_i  in  1  EX holds div/divu.
- unsigned_i  in  1  1 = multu/divu; 0 = signed.
- mthi_i / mtlo_i  in  1 each  EX holds mthi / mtlo.
- mfhi_i / mflo_i  in  1 each  EX holds mfhi / mflo.
- src_a_i  in  W  rs value (dividend / multiplicand / mt data).
- src_b_i  in  W  rt value (divisor / multiplier).
- flush_i  in  1  exception/ERET flush of EX and later stages.
- stall_o  out  1  freeze IF/ID/EX; combinational.
- busy_o  out  1  operation in flight.
- hilo_rd_o  out  W  mfhi/mflo read data; combinational.
- hi_o / lo_o  out  W each  current HI / LO.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, hi=lo=0, busy_o=0, stall_o=0 while inputs are idle, counter=0, hilo_rd_o=0.
- States: IDLE, MUL, DIV, FIX.
- stall_o = busy_o & (mul_i|div_i|mthi_i|mtlo_i|mfhi_i|mflo_i) & ~flush_i.
- Request acceptance: a request is accepted only on an edge where stall_o=0 and flush_i=0.
- While stalled, the pipeline re-presents identical inputs every cycle.
- Per-instruction request bits are mutually exclusive (decoder guarantee). If several are seen: start (mul/div) > mt > mf.
- IDLE + mul_i:
  - Register operands and the product (signed or unsigned 64-bit).
  - Go to MUL, counter = MUL_LAT-1.
- MUL:
  - Decrement the counter each cycle.
  - At counter=0, write {hi,lo} = product at that edge and go to IDLE.
  - busy_o is high exactly MUL_LAT cycles.
- IDLE + div_i:
  - Latch |a|, |b| (abs only when signed), the result signs, and the divide-by-zero flag.
  - Go to DIV, counter = 31.
- DIV:
  - One restoring-division step per cycle (shift remainder, trial subtract, set quotient bit).
  - After 32 steps go to FIX.
- FIX:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
  - Write lo = quotient, hi = remainder, go to IDLE.
  - Divide busy total = 33 cycles.
- Divide by zero: lo = 0xFFFFFFFF, hi = dividend (original, unsigned view). Cycle count unchanged.
- Signed 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. No trap.
- mthi_i / mtlo_i in IDLE: hi (or lo) = src_a_i at the edge. The other register is untouched.
- mfhi_i / mflo_i in IDLE: hilo_rd_o = hi / lo in the same cycle. Otherwise hilo_rd_o = 0.
- mf in the cycle right after a mt: returns the new value (register already updated).
- flush_i:
  - Any non-IDLE state goes to IDLE at the next edge, and busy_o drops then.
  - hi/lo keep their pre-operation values.
  - A request arriving in the same cycle as flush_i is dropped.
- A result completing on the same edge as flush_i is not written (flush wins).
- Reset mid-operation: immediate return to reset values. No partial write.
- Back-to-back:
  - A new mul/div presented during the last busy cycle stalls one cycle.
  - It is accepted in the first IDLE cycle, so there is no idle gap beyond that.

Decomposition:
- Package muldiv_pkg holds:
  - state enum {IDLE, MUL, DIV, FIX};
  - DIV_ITER = 32;
  - DIV0_QUOT = 32'hFFFFFFFF;
  - MUL_LAT default.
- One sub-module, muldiv_div_step: combinational single restoring step.
  - Inputs: remainder, dividend-shift, divisor.
  - Outputs: next remainder, next quotient bit.

Test Plan:
- Signed mult, a=0xFFFFFFFE, b=3, MUL_LAT=4 -> busy_o high 4 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- divu 100/7, mflo presented the cycle after acceptance -> stall_o high 33 cycles, released in the first IDLE cycle; then hilo_rd_o=14 and hi=2.
- Signed div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu 5/0 -> after 33 cycles lo=0xFFFFFFFF, hi=5.
- mthi 0x1234 then mtlo 0x5678; start div; flush_i at busy cycle 10 -> busy_o low the next cycle; hi=0x1234, lo=0x5678; mfhi returns 0x1234.
- rst_n low at MUL cycle 2 -> immediately hi=lo=0, busy_o=0, stall_o=0. After release, a mult 6*7 gives lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide controller.
// Holds the FSM state encoding plus the fixed divide iteration count and divide-by-zero quotient.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_e;

    localparam int          DIV_ITER    = 32;
    localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;
    localparam int          MUL_LAT_DEF = 4;
    localparam int          CNT_W       = 5;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder,
// then trial-subtract the divisor and keep the difference only if it did not go negative.
module muldiv_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_dvd_bit,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic         o_qbit
);

    logic [W:0] w_shift;
    logic [W:0] w_trial;

    // The remainder stays below the divisor, so the shifted value fits in W+1 bits
    // and the sign of the trial difference is its top bit.
    always_comb begin
        w_shift = {i_rem, i_dvd_bit};
        w_trial = w_shift - {1'b0, i_divisor};
        o_qbit  = ~w_trial[W];
        o_rem   = o_qbit ? w_trial[W-1:0] : w_shift[W-1:0];
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner for the MIPS EX stage: sequences multi-cycle mult/div, services mt/mf,
// and stalls the front of the pipeline when a HI/LO instruction meets an operation in flight.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int W       = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mul_i,
    input  logic         div_i,
    input  logic         unsigned_i,
    input  logic         mthi_i,
    input  logic         mtlo_i,
    input  logic         mfhi_i,
    input  logic         mflo_i,
    input  logic [W-1:0] src_a_i,
    input  logic [W-1:0] src_b_i,
    input  logic         flush_i,
    output logic         stall_o,
    output logic         busy_o,
    output logic [W-1:0] hilo_rd_o,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o,
    output state_e       dbg_state_o
);

    localparam logic [CNT_W-1:0] MUL_CNT0 = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'(DIV_ITER - 1);

    state_e               r_state;
    state_e               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*W-1:0]       r_prod;
    logic [W-1:0]         r_rem;
    logic [W-1:0]         r_quo;
    logic [W-1:0]         r_dvs;
    logic [W-1:0]         r_dvd;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_div0;
    logic [W-1:0]         r_hi;
    logic [W-1:0]         r_lo;

    logic                 w_any_req;
    logic                 w_accept;
    logic                 w_last;
    logic [2*W-1:0]       w_a_ext;
    logic [2*W-1:0]       w_b_ext;
    logic [2*W-1:0]       w_prod;
    logic [W-1:0]         w_abs_a;
    logic [W-1:0]         w_abs_b;
    logic [W-1:0]         w_step_rem;
    logic                 w_step_q;

    // Requests are only ever taken in IDLE; outside IDLE a request either stalls or is a no-op.
    assign w_any_req = mul_i | div_i | mthi_i | mtlo_i | mfhi_i | mflo_i;
    assign w_accept  = (r_state == IDLE) & ~flush_i;
    assign w_last    = (r_cnt == '0);

    // Sign/zero-extend to 64 bits so one truncated multiply serves both mult and multu.
    assign w_a_ext = unsigned_i ? {{W{1'b0}}, src_a_i} : {{W{src_a_i[W-1]}}, src_a_i};
    assign w_b_ext = unsigned_i ? {{W{1'b0}}, src_b_i} : {{W{src_b_i[W-1]}}, src_b_i};
    assign w_prod  = w_a_ext * w_b_ext;

    assign w_abs_a = (~unsigned_i & src_a_i[W-1]) ? -src_a_i : src_a_i;
    assign w_abs_b = (~unsigned_i & src_b_i[W-1]) ? -src_b_i : src_b_i;

    muldiv_div_step #(.W(W)) u_step (
        .i_rem     (r_rem),
        .i_dvd_bit (r_quo[W-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && mul_i)      w_next = MUL;
                else if (w_accept && div_i) w_next = DIV;
            end
            MUL:     if (flush_i || w_last) w_next = IDLE;
            DIV: begin
                if (flush_i)     w_next = IDLE;
                else if (w_last) w_next = FIX;
            end
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (r_state != IDLE);
        stall_o   = busy_o & w_any_req & ~flush_i;
        hilo_rd_o = '0;
        if (w_accept && !mul_i && !div_i && !mthi_i && !mtlo_i) begin
            if (mfhi_i)      hilo_rd_o = r_hi;
            else if (mflo_i) hilo_rd_o = r_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_prod  <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_dvd   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (mul_i) begin
                            r_prod <= w_prod;
                            r_cnt  <= MUL_CNT0;
                        end else if (div_i) begin
                            r_rem   <= '0;
                            r_quo   <= w_abs_a;
                            r_dvs   <= w_abs_b;
                            r_dvd   <= src_a_i;
                            r_neg_q <= ~unsigned_i & (src_a_i[W-1] ^ src_b_i[W-1]);
                            r_neg_r <= ~unsigned_i & src_a_i[W-1];
                            r_div0  <= (src_b_i == '0);
                            r_cnt   <= DIV_CNT0;
                        end else if (mthi_i) begin
                            r_hi <= src_a_i;
                        end else if (mtlo_i) begin
                            r_lo <= src_a_i;
                        end
                    end
                end
                MUL: begin
                    if (flush_i) begin
                        r_cnt <= '0;
                    end else if (w_last) begin
                        r_hi <= r_prod[2*W-1:W];
                        r_lo <= r_prod[W-1:0];
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DIV: begin
                    if (flush_i) begin
                        r_cnt <= '0;
                    end else begin
                        r_rem <= w_step_rem;
                        r_quo <= {r_quo[W-2:0], w_step_q};
                        if (!w_last) r_cnt <= r_cnt - 1'b1;
                    end
                end
                FIX: begin
                    // Divide by zero reports the original dividend in HI, whatever its sign.
                    if (!flush_i) begin
                        if (r_div0) begin
                            r_lo <= DIV0_QUOT;
                            r_hi <= r_dvd;
                        end else begin
                            r_lo <= r_neg_q ? -r_quo : r_quo;
                            r_hi <= r_neg_r ? -r_rem : r_rem;
                        end
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign hi_o        = r_hi;
    assign lo_o        = r_lo;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed cases plus random mult/div/mt/mf traffic against an arithmetic HI/LO model.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int W       = 32;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = DIV_ITER + 1;
    localparam int K_MUL = 0, K_DIV = 1, K_MTHI = 2, K_MTLO = 3, K_MFHI = 4, K_MFLO = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         mul_i = 1'b0, div_i = 1'b0, unsigned_i = 1'b0;
    logic         mthi_i = 1'b0, mtlo_i = 1'b0, mfhi_i = 1'b0, mflo_i = 1'b0;
    logic [W-1:0] src_a_i = '0, src_b_i = '0;
    logic         flush_i = 1'b0;
    logic         stall_o, busy_o;
    logic [W-1:0] hilo_rd_o, hi_o, lo_o;
    state_e       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Expected {hi,lo} at each operation end with its busy length; expected mf data with its stall length.
    logic [2*W-1:0] exp_q[$];
    int             len_q[$];
    logic [W-1:0]   rd_q[$];
    int             rd_stall_q[$];

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    bit           mon_en = 1'b0;
    int           busy_run = 0;
    int           stall_run = 0;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mul_i       (mul_i),
        .div_i       (div_i),
        .unsigned_i  (unsigned_i),
        .mthi_i      (mthi_i),
        .mtlo_i      (mtlo_i),
        .mfhi_i      (mfhi_i),
        .mflo_i      (mflo_i),
        .src_a_i     (src_a_i),
        .src_b_i     (src_b_i),
        .flush_i     (flush_i),
        .stall_o     (stall_o),
        .busy_o      (busy_o),
        .hilo_rd_o   (hilo_rd_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns);
        logic [63:0] ua, ub;
        longint      sa, sb;
        if (uns) begin
            ua = {32'b0, a};
            ub = {32'b0, b};
            return ua * ub;
        end
        sa = $signed(a);
        sb = $signed(b);
        return 64'(sa * sb);
    endfunction

    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns);
        longint sa, sb, q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (uns) return {a % b, a / b};
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [2*W-1:0] e;
        logic [W-1:0]   rd;
        int             l, s;
        if (!mon_en) begin
            busy_run  = 0;
            stall_run = 0;
        end else begin
            if (busy_o) begin
                busy_run++;
            end else if (busy_run > 0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_completion: got busy run %0d expected none", busy_run);
                end else begin
                    e = exp_q.pop_front();
                    l = len_q.pop_front();
                    chk("result_hi", 64'(hi_o), 64'(e[63:32]));
                    chk("result_lo", 64'(lo_o), 64'(e[31:0]));
                    chk("busy_len", 64'(busy_run), 64'(l));
                end
                busy_run = 0;
            end
            if (stall_o) stall_run++;
            if ((mfhi_i || mflo_i) && !stall_o && !flush_i) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_mf: got read 0x%0h expected no read", hilo_rd_o);
                end else begin
                    rd = rd_q.pop_front();
                    s  = rd_stall_q.pop_front();
                    chk("mf_data", 64'(hilo_rd_o), 64'(rd));
                    if (s >= 0) chk("mf_stall_len", 64'(stall_run), 64'(s));
                end
            end else begin
                chk("rd_zero", 64'(hilo_rd_o), 64'(0));
            end
            if (!stall_o) stall_run = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        mul_i = 0; div_i = 0; mthi_i = 0; mtlo_i = 0; mfhi_i = 0; mflo_i = 0;
        unsigned_i = 0; src_a_i = '0; src_b_i = '0;
    endtask

    task automatic wait_accept();
        int g = 0;
        @(negedge clk);
        while (stall_o && g < 200) begin
            g++;
            @(negedge clk);
        end
        if (stall_o) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got stall after %0d cycles expected release", g);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy_o && g < 200) begin
            g++;
            @(posedge clk);
            #1;
        end
        if (busy_o) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", g);
        end
    endtask

    task automatic do_op(input int kind, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic uns, input int exp_stall);
        logic [2*W-1:0] r;
        case (kind)
            K_MUL: begin
                r = ref_mul(a, b, uns);
                exp_q.push_back(r); len_q.push_back(MUL_LAT);
                m_hi = r[63:32]; m_lo = r[31:0];
            end
            K_DIV: begin
                r = ref_div(a, b, uns);
                exp_q.push_back(r); len_q.push_back(DIV_LAT);
                m_hi = r[63:32]; m_lo = r[31:0];
            end
            K_MTHI: m_hi = a;
            K_MTLO: m_lo = a;
            K_MFHI: begin rd_q.push_back(m_hi); rd_stall_q.push_back(exp_stall); end
            default: begin rd_q.push_back(m_lo); rd_stall_q.push_back(exp_stall); end
        endcase
        mul_i  = (kind == K_MUL);
        div_i  = (kind == K_DIV);
        mthi_i = (kind == K_MTHI);
        mtlo_i = (kind == K_MTLO);
        mfhi_i = (kind == K_MFHI);
        mflo_i = (kind == K_MFLO);
        unsigned_i = uns;
        src_a_i = a;
        src_b_i = b;
        wait_accept();
        clear_inputs();
    endtask

    // Start a divide and flush it while in busy cycle 'at'; HI/LO must stay as before.
    task automatic do_flush_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns, input int at);
        exp_q.push_back({m_hi, m_lo});
        len_q.push_back(at);
        div_i = 1; unsigned_i = uns; src_a_i = a; src_b_i = b;
        wait_accept();
        clear_inputs();
        chk("state_div", 64'(dbg_state), 64'(DIV));
        repeat (at - 1) begin
            @(posedge clk);
            #1;
        end
        flush_i = 1;
        @(posedge clk);
        #1;
        flush_i = 0;
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hi", 64'(hi_o), 64'(0));
        chk("reset_lo", 64'(lo_o), 64'(0));
        chk("reset_busy", 64'(busy_o), 64'(0));
        chk("reset_stall", 64'(stall_o), 64'(0));
        chk("reset_rd", 64'(hilo_rd_o), 64'(0));
        chk("reset_state", 64'(dbg_state), 64'(IDLE));
        @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1 mon_en = 1;

        // Signed mult -2 * 3.
        do_op(K_MUL, 32'hFFFF_FFFE, 32'd3, 1'b0, -1);
        wait_idle();
        chk("tp_mul_hi", 64'(hi_o), 64'hFFFF_FFFF);
        chk("tp_mul_lo", 64'(lo_o), 64'hFFFF_FFFA);

        // divu 100/7 with mflo right behind it: stalls for the whole divide.
        do_op(K_DIV, 32'd100, 32'd7, 1'b1, -1);
        do_op(K_MFLO, '0, '0, 1'b0, 33);
        chk("tp_divu_lo", 64'(lo_o), 64'd14);
        chk("tp_divu_hi", 64'(hi_o), 64'd2);

        do_op(K_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        wait_idle();
        chk("tp_sdiv_lo", 64'(lo_o), 64'hFFFF_FFFD);
        chk("tp_sdiv_hi", 64'(hi_o), 64'hFFFF_FFFF);

        do_op(K_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        wait_idle();
        chk("tp_ovf_lo", 64'(lo_o), 64'h8000_0000);
        chk("tp_ovf_hi", 64'(hi_o), 64'h0);

        do_op(K_DIV, 32'd5, 32'd0, 1'b1, -1);
        wait_idle();
        chk("tp_div0_lo", 64'(lo_o), 64'hFFFF_FFFF);
        chk("tp_div0_hi", 64'(hi_o), 64'd5);

        // mt then flushed divide.
        do_op(K_MTHI, 32'h1234, '0, 1'b0, -1);
        do_op(K_MTLO, 32'h5678, '0, 1'b0, -1);
        do_flush_div(32'd1000, 32'd3, 1'b1, 10);
        chk("flush_busy_low", 64'(busy_o), 64'(0));
        chk("flush_hi", 64'(hi_o), 64'h1234);
        chk("flush_lo", 64'(lo_o), 64'h5678);
        do_op(K_MFHI, '0, '0, 1'b0, -1);

        // A request arriving with flush is dropped.
        mthi_i = 1; src_a_i = 32'hDEAD_BEEF; flush_i = 1;
        @(posedge clk);
        #1;
        clear_inputs();
        flush_i = 0;
        do_op(K_MFHI, '0, '0, 1'b0, -1);
        do_op(K_MFLO, '0, '0, 1'b0, 0);

        // Reset in MUL cycle 2.
        wait_idle();
        @(negedge clk);
        mon_en = 0;
        @(posedge clk);
        #1;
        mul_i = 1; src_a_i = 32'd9; src_b_i = 32'd9;
        @(posedge clk);
        #1;
        clear_inputs();
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("rst_mid_hi", 64'(hi_o), 64'(0));
        chk("rst_mid_lo", 64'(lo_o), 64'(0));
        chk("rst_mid_busy", 64'(busy_o), 64'(0));
        chk("rst_mid_stall", 64'(stall_o), 64'(0));
        chk("rst_mid_state", 64'(dbg_state), 64'(IDLE));
        @(posedge clk);
        #1 rst_n = 1;
        m_hi = '0; m_lo = '0;
        mon_en = 1;
        do_op(K_MUL, 32'd6, 32'd7, 1'b0, -1);
        wait_idle();
        chk("tp_mul67_lo", 64'(lo_o), 64'd42);
        chk("tp_mul67_hi", 64'(hi_o), 64'd0);

        // Back-to-back starts.
        do_op(K_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1);
        do_op(K_DIV, 32'hFFFF_FFFF, 32'd10, 1'b1, -1);
        do_op(K_MUL, 32'h8000_0000, 32'h8000_0000, 1'b0, -1);
        do_op(K_MFHI, '0, '0, 1'b0, -1);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            do_op(int'($urandom_range(0, 5)), rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)), -1);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 6)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        wait_idle();
        @(posedge clk);
        #1;
        chk("queues_drained", 64'(exp_q.size() + rd_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
